// File: rtl/des_pkg.sv
// Shared DES S-box constants, the standard S1..S8 tables and the 6-bit chunk to table address mapping.
package des_pkg;

    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 4;
    localparam int SBOX_DEPTH = 64;
    localparam int MAX_BOX    = 8;

    // Standard DES tables, row-major {row, col}; entry 0 sits in the most significant nibble.
    localparam logic [255:0] SBOX_STD [MAX_BOX] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [5:0] sbox_addr(input logic [5:0] b);
        return {b[5], b[0], b[4:1]};
    endfunction

    function automatic logic [3:0] sbox_std_entry(input int box, input int idx);
        return SBOX_STD[box][255-4*idx -: 4];
    endfunction

endpackage

// File: rtl/des_sbox_array_if.sv
// Streaming and table-write signals of the S-box array, grouped for the round datapath.
interface des_sbox_array_if #(
    parameter int NUM_BOX = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [6*NUM_BOX-1:0]   din;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NUM_BOX-1:0]   dout;
    logic                   wr_en;
    logic [2:0]             wr_box;
    logic [5:0]             wr_addr;
    logic [3:0]             wr_data;
    logic                   wr_done;
    logic                   busy;

    modport master (
        output in_valid, din, out_ready, wr_en, wr_box, wr_addr, wr_data,
        input  in_ready, out_valid, dout, wr_done, busy
    );

    modport slave (
        input  in_valid, din, out_ready, wr_en, wr_box, wr_addr, wr_data,
        output in_ready, out_valid, dout, wr_done, busy
    );
endinterface

// File: rtl/des_sbox_ram.sv
// One 64x4 S-box table: single write port, registered read with enable, preloaded with the standard table.
module des_sbox_ram
  import des_pkg::*;
#(
  parameter string INIT_FILE = "",
  parameter int    BASE      = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rd_en,
  input  logic [5:0] rd_addr,
  output logic [3:0] q,
  input  logic       we,
  input  logic [5:0] wr_addr,
  input  logic [3:0] wr_data
);

  logic [SBOX_OUT_W-1:0] mem [SBOX_DEPTH];

  initial begin
    for (int i = 0; i < SBOX_DEPTH; i++) mem[i] = sbox_std_entry(BASE/SBOX_DEPTH, i);
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn)      q <= '0;
    else if (rd_en) q <= mem[rd_addr];
  end

endmodule

// File: rtl/des_sbox_array.sv
// Parallel DES S-box substitution with valid/ready streaming, runtime table rewrite and optional output register.
module des_sbox_array
    import des_pkg::*;
#(
    parameter int    NUM_BOX   = 8,
    parameter bit    REG_OUT   = 1,
    parameter string INIT_FILE = "Sbox_all.txt"
) (
    input  logic            clk,
    input  logic            rstn,
    des_sbox_array_if.slave bus
);

    logic                 vld_p1;
    logic                 vld_p2;
    logic                 free_p1;
    logic                 in_fire;
    logic                 busy_int;
    logic                 wr_commit;
    logic [4*NUM_BOX-1:0] data_p1;

    // Writes wait for an empty pipeline so in-flight words keep the old table.
    assign busy_int  = vld_p1 | vld_p2;
    assign wr_commit = rstn & bus.wr_en & ~busy_int;
    assign bus.wr_done = wr_commit;
    assign bus.busy    = busy_int;

    assign bus.in_ready = ~bus.wr_en & free_p1;
    assign in_fire      = bus.in_valid & bus.in_ready;

    // ---- stage p1: table read register (read enable = load condition) ----
    generate
        for (genvar i = 0; i < NUM_BOX; i++) begin : g_box
            logic [SBOX_IN_W-1:0] chunk;
            assign chunk = bus.din[SBOX_IN_W*(NUM_BOX-i)-1 -: SBOX_IN_W];

            des_sbox_ram #(
                .INIT_FILE (INIT_FILE),
                .BASE      (SBOX_DEPTH*i)
            ) u_ram (
                .clk     (clk),
                .rstn    (rstn),
                .rd_en   (free_p1),
                .rd_addr (sbox_addr(chunk)),
                .q       (data_p1[SBOX_OUT_W*(NUM_BOX-i)-1 -: SBOX_OUT_W]),
                .we      (wr_commit && (bus.wr_box == 3'(i))),
                .wr_addr (bus.wr_addr),
                .wr_data (bus.wr_data)
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn)        vld_p1 <= 1'b0;
        else if (free_p1) vld_p1 <= in_fire;
    end

    // ---- stage p2: optional output register ----
    generate
        if (REG_OUT) begin : g_reg_out
            logic                 free_p2;
            logic [4*NUM_BOX-1:0] data_p2;

            assign free_p2 = ~vld_p2 | bus.out_ready;
            assign free_p1 = ~vld_p1 | free_p2;

            always_ff @(posedge clk) begin
                if (!rstn)        vld_p2 <= 1'b0;
                else if (free_p2) vld_p2 <= vld_p1;
            end

            always_ff @(posedge clk) begin
                if (!rstn)        data_p2 <= '0;
                else if (free_p2) data_p2 <= data_p1;
            end

            assign bus.out_valid = vld_p2;
            assign bus.dout      = data_p2;
        end else begin : g_direct
            assign vld_p2        = 1'b0;
            assign free_p1       = ~vld_p1 | bus.out_ready;
            assign bus.out_valid = vld_p1;
            assign bus.dout      = data_p1;
        end
    endgenerate

endmodule
